generic_sram_axi4_master_bridge: RTL and testbench
==================================================

GENERIC_SRAM_AXI4_MASTER_BRIDGE -- requirements
Module: generic_sram_axi4_master_bridge

Interface
REQ-001 Parameter MEM_ADDR_BITS, default 10: word-address width on the SRAM side.
REQ-002 Parameter AXI_ADDRESS_WIDTH, default 32: AXI byte-address width.
REQ-003 Parameter AXI_DATA_WIDTH, default 32: data width on both sides, a power of two, minimum 8.
REQ-004 Parameter AXI_ID_WIDTH, default 4: AXI ID width.
REQ-005 Parameter AXI_ID, default 0: ID driven on AWID and ARID.
REQ-006 Parameter BASE_ADDR, default 0: byte offset added to every translated address.
REQ-007 Port clk, input, 1: sole clock; one clock; all logic on the rising edge.
REQ-008 Port rst_n, input, 1: reset is synchronous and active-low.
REQ-009 Port sram_req, input, 1: request valid, held until sram_ack.
REQ-010 Port sram_write_en, input, 1: 1 = write, 0 = read; sampled with sram_req.
REQ-011 Port sram_addr, input, MEM_ADDR_BITS: word address.
REQ-012 Ports sram_write_data (input, AXI_DATA_WIDTH) and sram_byte_en (input, AXI_DATA_WIDTH/8): write payload and byte lanes.
REQ-013 Port sram_read_data, output, AXI_DATA_WIDTH: registered read result, valid while sram_ack=1.
REQ-014 Ports sram_ack (output, 1) and sram_err (output, 1): one-cycle completion pulse; err qualifies ack.
REQ-015 AW channel: AWADDR, AWID, AWLEN(8), AWSIZE(3), AWBURST(2), AWVALID outputs; AWREADY input.
REQ-016 W channel: WDATA, WSTRB, WLAST, WVALID outputs; WREADY input.
REQ-017 B channel: BID, BRESP(2), BVALID inputs; BREADY output.
REQ-018 AR channel: ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARVALID outputs; ARREADY input.
REQ-019 R channel: RDATA, RID, RRESP, RLAST, RVALID inputs; RREADY output.

Function
REQ-020 Every transaction is single-beat: LEN=0, SIZE=log2(AXI_DATA_WIDTH/8), BURST=INCR, WLAST=1.
REQ-021 Address = BASE_ADDR + (sram_addr << SIZE), zero-extended to AXI_ADDRESS_WIDTH and wrapping modulo 2^AXI_ADDRESS_WIDTH.
REQ-022 FSM states: IDLE, WR (AW/W pending), WR_RESP, RD_ADDR, RD_DATA, ACK.
REQ-023 IDLE plus sram_req: capture addr, data and strobes; go to WR when write_en=1, otherwise RD_ADDR.
REQ-024 WR: AWVALID and WVALID rise together one cycle after capture; each drops independently after its own handshake; when both are done, go to WR_RESP.
REQ-025 AW and W handshakes may complete in either order or in the same cycle; no payload changes while its VALID is high.
REQ-026 WR_RESP: BREADY=1; on BVALID go to ACK and set err when BRESP!=OKAY.
REQ-027 RD_ADDR: ARVALID=1 until ARREADY, then RD_DATA.
REQ-028 RD_DATA: RREADY=1; on RVALID register RDATA and set err when RRESP!=OKAY or RLAST=0; then ACK.
REQ-029 ACK: sram_ack=1 for exactly one cycle, then IDLE; the next request is accepted no earlier than the cycle after ack.
REQ-030 sram_req in any non-IDLE state is ignored, not queued.
REQ-031 BREADY and RREADY are 0 outside WR_RESP and RD_DATA respectively.
REQ-032 BID and RID are not checked.
REQ-033 Minimum latency with zero-wait slave: write req→ack 4 cycles; read req→ack 4 cycles.

Reset
REQ-034 With rst_n=0 at a clock edge: state=IDLE; all VALID/READY outputs, sram_ack and sram_err are 0; sram_read_data is 0.
REQ-035 Reset mid-transaction abandons it with no ack; the environment resets the slave concurrently.

Structure
REQ-036 Package axi4_pkg holds the BURST and RESP encodings and the FSM state enum.
REQ-037 Single module, no sub-modules.

Verification
REQ-038 Write addr=0x010, data=0xDEADBEEF, byte_en=0xF, zero-wait slave: expect AWADDR=0x40, WSTRB=0xF, ack 4 cycles after req, err=0.
REQ-039 Read the same address: expect ARADDR=0x40; sram_read_data=0xDEADBEEF on ack.
REQ-040 Write byte_en=0x5 with AWREADY delayed 3 cycles and WREADY immediate: W completes first, AW completes later, exactly one ack.
REQ-041 Read answered with RRESP=SLVERR (2'b10): ack with err=1.
REQ-042 BASE_ADDR=0x1000_0000, addr=0x3FF: expect AWADDR=0x1000_0FFC.
REQ-043 Assert rst_n=0 while in WR_RESP: all VALIDs are 0 the next cycle, no ack; a subsequent read completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// AXI4 encodings and bridge FSM state shared by the SRAM-to-AXI4 master bridge.
// Single-beat transfers only; SIZE is derived from the data width.
package axi4_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_ACK
   } bridge_state_t;

   function automatic logic [2:0] axsize(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/generic_sram_axi4_master_bridge.sv
// Turns a held SRAM-style request into one single-beat AXI4 read or write; 4 cycles req->ack
// with a zero-wait slave. Slave stalls hold the FSM; requests arriving while busy are ignored.
module generic_sram_axi4_master_bridge
   import axi4_pkg::*;
#(
   parameter int                           MEM_ADDR_BITS     = 10,
   parameter int                           AXI_ADDRESS_WIDTH = 32,
   parameter int                           AXI_DATA_WIDTH    = 32,
   parameter int                           AXI_ID_WIDTH      = 4,
   parameter int                           AXI_ID            = 0,
   parameter logic [AXI_ADDRESS_WIDTH-1:0] BASE_ADDR         = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,

   input  logic                           sram_req,
   input  logic                           sram_write_en,
   input  logic [MEM_ADDR_BITS-1:0]       sram_addr,
   input  logic [AXI_DATA_WIDTH-1:0]      sram_write_data,
   input  logic [AXI_DATA_WIDTH/8-1:0]    sram_byte_en,
   output logic [AXI_DATA_WIDTH-1:0]      sram_read_data,
   output logic                           sram_ack,
   output logic                           sram_err,

   output logic [AXI_ADDRESS_WIDTH-1:0]   AWADDR,
   output logic [AXI_ID_WIDTH-1:0]        AWID,
   output logic [7:0]                     AWLEN,
   output logic [2:0]                     AWSIZE,
   output logic [1:0]                     AWBURST,
   output logic                           AWVALID,
   input  logic                           AWREADY,

   output logic [AXI_DATA_WIDTH-1:0]      WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0]    WSTRB,
   output logic                           WLAST,
   output logic                           WVALID,
   input  logic                           WREADY,

   input  logic [AXI_ID_WIDTH-1:0]        BID,
   input  logic [1:0]                     BRESP,
   input  logic                           BVALID,
   output logic                           BREADY,

   output logic [AXI_ADDRESS_WIDTH-1:0]   ARADDR,
   output logic [AXI_ID_WIDTH-1:0]        ARID,
   output logic [7:0]                     ARLEN,
   output logic [2:0]                     ARSIZE,
   output logic [1:0]                     ARBURST,
   output logic                           ARVALID,
   input  logic                           ARREADY,

   input  logic [AXI_DATA_WIDTH-1:0]      RDATA,
   input  logic [AXI_ID_WIDTH-1:0]        RID,
   input  logic [1:0]                     RRESP,
   input  logic                           RLAST,
   input  logic                           RVALID,
   output logic                           RREADY
);

   localparam int         STRB_W = AXI_DATA_WIDTH / 8;
   localparam logic [2:0] C_SIZE = axsize(AXI_DATA_WIDTH);

   bridge_state_t                  r_state;
   logic [AXI_ADDRESS_WIDTH-1:0]   r_addr;
   logic [AXI_DATA_WIDTH-1:0]      r_wdata;
   logic [STRB_W-1:0]              r_wstrb;
   logic [AXI_DATA_WIDTH-1:0]      r_rdata;
   logic                           r_awvalid;
   logic                           r_wvalid;
   logic                           r_bready;
   logic                           r_arvalid;
   logic                           r_rready;
   logic                           r_ack;
   logic                           r_err;

   logic [AXI_ADDRESS_WIDTH-1:0]   w_xlat_addr;
   logic                           w_aw_done;
   logic                           w_w_done;
   logic                           w_unused_ids;

   // Word address scaled to bytes; the sum wraps naturally at the AXI address width.
   assign w_xlat_addr  = BASE_ADDR + (AXI_ADDRESS_WIDTH'(sram_addr) << C_SIZE);
   assign w_aw_done    = !r_awvalid || AWREADY;
   assign w_w_done     = !r_wvalid  || WREADY;
   assign w_unused_ids = ^{BID, RID};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_rdata   <= '0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (sram_req) begin
                  r_addr  <= w_xlat_addr;
                  r_wdata <= sram_write_data;
                  r_wstrb <= sram_byte_en;
                  r_err   <= 1'b0;
                  if (sram_write_en) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_state   <= ST_WR;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_ADDR;
                  end
               end
            end
            ST_WR: begin
               // AW and W retire independently; leave once neither is still pending.
               if (AWREADY) r_awvalid <= 1'b0;
               if (WREADY)  r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_bready <= 1'b1;
                  r_state  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (BVALID) begin
                  r_bready <= 1'b0;
                  r_err    <= (BRESP != RESP_OKAY);
                  r_ack    <= 1'b1;
                  r_state  <= ST_ACK;
               end
            end
            ST_RD_ADDR: begin
               if (ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (RVALID) begin
                  r_rready <= 1'b0;
                  r_rdata  <= RDATA;
                  r_err    <= (RRESP != RESP_OKAY) || !RLAST;
                  r_ack    <= 1'b1;
                  r_state  <= ST_ACK;
               end
            end
            ST_ACK: begin
               r_err   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sram_read_data = r_rdata;
   assign sram_ack       = r_ack;
   assign sram_err       = r_err;

   assign AWADDR  = r_addr;
   assign AWID    = AXI_ID_WIDTH'(AXI_ID);
   assign AWLEN   = 8'd0;
   assign AWSIZE  = C_SIZE;
   assign AWBURST = BURST_INCR;
   assign AWVALID = r_awvalid;

   assign WDATA   = r_wdata;
   assign WSTRB   = r_wstrb;
   assign WLAST   = 1'b1;
   assign WVALID  = r_wvalid;

   assign BREADY  = r_bready;

   assign ARADDR  = r_addr;
   assign ARID    = AXI_ID_WIDTH'(AXI_ID);
   assign ARLEN   = 8'd0;
   assign ARSIZE  = C_SIZE;
   assign ARBURST = BURST_INCR;
   assign ARVALID = r_arvalid;

   assign RREADY  = r_rready;

endmodule

// File: tb/tb_generic_sram_axi4_master_bridge.sv
// Scoreboard bench: a behavioural AXI slave with configurable stalls/responses drives the bridge;
// expected addresses, beats and completions are queued at request time and checked as they appear.
module tb_generic_sram_axi4_master_bridge;
   import axi4_pkg::*;

   localparam int AW = 32, DW = 32, IW = 4, MAB = 10, SW = DW / 8;

   logic clk;
   logic rst_n;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic           sram_req, sram_write_en;
   logic [MAB-1:0] sram_addr;
   logic [DW-1:0]  sram_write_data, sram_read_data;
   logic [SW-1:0]  sram_byte_en;
   logic           sram_ack, sram_err;
   logic [AW-1:0]  AWADDR, ARADDR;
   logic [IW-1:0]  AWID, ARID, BID, RID;
   logic [7:0]     AWLEN, ARLEN;
   logic [2:0]     AWSIZE, ARSIZE;
   logic [1:0]     AWBURST, ARBURST, BRESP, RRESP;
   logic           AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic           ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [DW-1:0]  WDATA, RDATA;
   logic [SW-1:0]  WSTRB;

   generic_sram_axi4_master_bridge u_dut (
      .clk(clk), .rst_n(rst_n),
      .sram_req(sram_req), .sram_write_en(sram_write_en), .sram_addr(sram_addr),
      .sram_write_data(sram_write_data), .sram_byte_en(sram_byte_en),
      .sram_read_data(sram_read_data), .sram_ack(sram_ack), .sram_err(sram_err),
      .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   // Second instance only exercises a non-zero BASE_ADDR at the top of the word range.
   logic           x_req, x_we, x_ack, x_err;
   logic [MAB-1:0] x_addr;
   logic [DW-1:0]  x_wdata, x_rdata, x_WDATA, x_RDATA;
   logic [SW-1:0]  x_be, x_WSTRB;
   logic [AW-1:0]  x_AWADDR, x_ARADDR;
   logic [IW-1:0]  x_AWID, x_ARID, x_BID, x_RID;
   logic [7:0]     x_AWLEN, x_ARLEN;
   logic [2:0]     x_AWSIZE, x_ARSIZE;
   logic [1:0]     x_AWBURST, x_ARBURST, x_BRESP, x_RRESP;
   logic           x_AWVALID, x_AWREADY, x_WLAST, x_WVALID, x_WREADY, x_BVALID, x_BREADY;
   logic           x_ARVALID, x_ARREADY, x_RLAST, x_RVALID, x_RREADY;

   generic_sram_axi4_master_bridge #(.BASE_ADDR(32'h1000_0000)) u_dut_base (
      .clk(clk), .rst_n(rst_n),
      .sram_req(x_req), .sram_write_en(x_we), .sram_addr(x_addr),
      .sram_write_data(x_wdata), .sram_byte_en(x_be),
      .sram_read_data(x_rdata), .sram_ack(x_ack), .sram_err(x_err),
      .AWADDR(x_AWADDR), .AWID(x_AWID), .AWLEN(x_AWLEN), .AWSIZE(x_AWSIZE), .AWBURST(x_AWBURST),
      .AWVALID(x_AWVALID), .AWREADY(x_AWREADY),
      .WDATA(x_WDATA), .WSTRB(x_WSTRB), .WLAST(x_WLAST), .WVALID(x_WVALID), .WREADY(x_WREADY),
      .BID(x_BID), .BRESP(x_BRESP), .BVALID(x_BVALID), .BREADY(x_BREADY),
      .ARADDR(x_ARADDR), .ARID(x_ARID), .ARLEN(x_ARLEN), .ARSIZE(x_ARSIZE), .ARBURST(x_ARBURST),
      .ARVALID(x_ARVALID), .ARREADY(x_ARREADY),
      .RDATA(x_RDATA), .RID(x_RID), .RRESP(x_RRESP), .RLAST(x_RLAST), .RVALID(x_RVALID),
      .RREADY(x_RREADY)
   );

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   typedef struct {
      bit          is_rd;
      bit          err;
      logic [31:0] rdata;
   } ack_exp_t;

   logic [31:0] exp_aw_q[$];
   logic [31:0] exp_ar_q[$];
   logic [35:0] exp_w_q[$];
   ack_exp_t    exp_ack_q[$];
   bit   [31:0] exp_mem[int];
   bit   [31:0] slv_mem[int];

   // Slave configuration, written by the stimulus thread only.
   int          aw_delay = 0, w_delay = 0;
   logic [1:0]  b_resp_cfg = RESP_OKAY, r_resp_cfg = RESP_OKAY;
   logic        r_last_cfg = 1'b1;
   bit          b_hold = 0;

   // Slave/monitor state, owned by the slave process.
   int          cyc_cnt = 0, aw_cyc = 0, w_cyc = 0, ack_cnt = 0, aw_wait = 0, w_wait = 0;
   bit          aw_got, w_got, b_pend, b_taken, ar_got, r_taken, aw_ev, w_ev, ar_ev;
   logic [31:0] aw_addr_s, ar_addr_s, w_data_s;
   logic [3:0]  w_strb_s;
   logic        w_last_s;
   logic [16:0] aw_fix_s, ar_fix_s;

   always begin
      @(posedge clk);
      cyc_cnt++;
      if (rst_n) begin
         if (sram_ack) ack_cnt++;
         if (AWVALID && AWREADY) begin
            aw_got = 1; aw_ev = 1; aw_cyc = cyc_cnt; aw_addr_s = AWADDR;
            aw_fix_s = {AWID, AWLEN, AWSIZE, AWBURST};
         end
         if (WVALID && WREADY) begin
            w_got = 1; w_ev = 1; w_cyc = cyc_cnt; w_data_s = WDATA; w_strb_s = WSTRB; w_last_s = WLAST;
         end
         if (BVALID && BREADY) b_taken = 1;
         if (ARVALID && ARREADY) begin
            ar_got = 1; ar_ev = 1; ar_addr_s = ARADDR;
            ar_fix_s = {ARID, ARLEN, ARSIZE, ARBURST};
         end
         if (RVALID && RREADY) r_taken = 1;
      end
      @(negedge clk);
      if (!rst_n) begin
         AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
         ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0;
         aw_got = 0; w_got = 0; b_pend = 0; b_taken = 0; ar_got = 0; r_taken = 0;
         aw_ev = 0; w_ev = 0; ar_ev = 0; aw_wait = 0; w_wait = 0;
      end else begin
         if (aw_ev) begin
            aw_ev = 0;
            if (exp_aw_q.size() == 0) check_eq("aw_unexpected", 0, 1);
            else check_eq("awaddr", aw_addr_s, exp_aw_q.pop_front());
            check_eq("aw_fields", aw_fix_s, {4'd0, 8'd0, 3'd2, BURST_INCR});
         end
         if (w_ev) begin
            w_ev = 0;
            if (exp_w_q.size() == 0) check_eq("w_unexpected", 0, 1);
            else check_eq("w_strb_data", {w_strb_s, w_data_s}, exp_w_q.pop_front());
            check_eq("wlast", w_last_s, 1);
         end
         if (ar_ev) begin
            ar_ev = 0;
            if (exp_ar_q.size() == 0) check_eq("ar_unexpected", 0, 1);
            else check_eq("araddr", ar_addr_s, exp_ar_q.pop_front());
            check_eq("ar_fields", ar_fix_s, {4'd0, 8'd0, 3'd2, BURST_INCR});
         end
         if (AWVALID && !aw_got) begin AWREADY = (aw_wait >= aw_delay); aw_wait++; end
         else begin AWREADY = 0; aw_wait = 0; end
         if (WVALID && !w_got) begin WREADY = (w_wait >= w_delay); w_wait++; end
         else begin WREADY = 0; w_wait = 0; end
         if (b_taken) begin
            BVALID = 0; b_pend = 0; b_taken = 0; aw_got = 0; w_got = 0;
         end else begin
            if (aw_got && w_got && !b_pend) begin
               b_pend = 1;
               slv_mem[int'(aw_addr_s >> 2)] = merge(slv_mem.exists(int'(aw_addr_s >> 2)) ?
                  slv_mem[int'(aw_addr_s >> 2)] : 32'h0, w_data_s, w_strb_s);
            end
            if (b_pend && !b_hold && !BVALID) begin BVALID = 1; BRESP = b_resp_cfg; end
         end
         ARREADY = ARVALID && !ar_got;
         if (r_taken) begin
            RVALID = 0; RLAST = 0; ar_got = 0; r_taken = 0;
         end else if (ar_got && !RVALID) begin
            RVALID = 1; RRESP = r_resp_cfg; RLAST = r_last_cfg;
            RDATA = slv_mem.exists(int'(ar_addr_s >> 2)) ? slv_mem[int'(ar_addr_s >> 2)] : 32'h0;
         end
      end
   end

   // Latency counts the cycle in which req is first presented as cycle 1.
   task automatic do_req(input bit we, input logic [9:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input bit exp_err, input int exp_lat,
                         input string tag);
      ack_exp_t e;
      int       cyc;
      bit       got;
      logic [31:0] ba;
      ba = 32'(addr) << 2;
      e.is_rd = !we;
      e.err   = exp_err;
      if (we) begin
         exp_aw_q.push_back(ba);
         exp_w_q.push_back({be, data});
         exp_mem[int'(addr)] = merge(exp_mem.exists(int'(addr)) ? exp_mem[int'(addr)] : 32'h0,
                                     data, be);
         e.rdata = 32'h0;
      end else begin
         exp_ar_q.push_back(ba);
         e.rdata = exp_mem.exists(int'(addr)) ? exp_mem[int'(addr)] : 32'h0;
      end
      exp_ack_q.push_back(e);
      @(negedge clk);
      sram_req = 1; sram_write_en = we; sram_addr = addr; sram_write_data = data; sram_byte_en = be;
      cyc = 1;
      got = 0;
      while (!got && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         got = sram_ack;
      end
      check_eq({tag, "_ack"}, got, 1);
      if (got) begin
         e = exp_ack_q.pop_front();
         check_eq({tag, "_err"}, sram_err, e.err);
         if (e.is_rd) check_eq({tag, "_rdata"}, sram_read_data, e.rdata);
         check_eq({tag, "_lat"}, cyc, exp_lat);
      end else begin
         exp_ack_q.delete();
      end
      sram_req = 0;
      @(posedge clk); #1;
      check_eq({tag, "_ack_drop"}, {sram_ack, sram_err}, 2'b00);
   endtask

   int a0, n;

   initial begin
      rst_n = 0;
      sram_req = 0; sram_write_en = 0; sram_addr = '0; sram_write_data = '0; sram_byte_en = '0;
      x_req = 0; x_we = 0; x_addr = '0; x_wdata = '0; x_be = '0;
      x_AWREADY = 0; x_WREADY = 0; x_BID = '0; x_BRESP = '0; x_BVALID = 0;
      x_ARREADY = 0; x_RDATA = '0; x_RID = '0; x_RRESP = '0; x_RLAST = 0; x_RVALID = 0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valids", {AWVALID, WVALID, ARVALID}, 3'b000);
      check_eq("rst_readys", {BREADY, RREADY}, 2'b00);
      check_eq("rst_ack_err", {sram_ack, sram_err}, 2'b00);
      check_eq("rst_rdata", sram_read_data, 32'h0);
      @(negedge clk);
      rst_n = 1;

      do_req(1, 10'h010, 32'hDEADBEEF, 4'hF, 0, 4, "wr0");
      do_req(0, 10'h010, 32'h0, 4'h0, 0, 4, "rd0");

      aw_delay = 3;
      #1 a0 = ack_cnt;
      do_req(1, 10'h020, 32'h11223344, 4'h5, 0, 7, "wr_awdly");
      aw_delay = 0;
      check_eq("w_then_aw_gap", 32'(aw_cyc - w_cyc), 32'd3);
      repeat (3) @(posedge clk);
      #1 check_eq("wr_awdly_one_ack", 32'(ack_cnt - a0), 32'd1);
      do_req(0, 10'h020, 32'h0, 4'h0, 0, 4, "rd_partial");

      w_delay = 2;
      do_req(1, 10'h030, 32'hCAFEF00D, 4'hF, 0, 6, "wr_wdly");
      w_delay = 0;
      check_eq("aw_then_w_gap", 32'(w_cyc - aw_cyc), 32'd2);

      r_resp_cfg = RESP_SLVERR;
      do_req(0, 10'h010, 32'h0, 4'h0, 1, 4, "rd_slverr");
      r_resp_cfg = RESP_OKAY;
      r_last_cfg = 0;
      do_req(0, 10'h030, 32'h0, 4'h0, 1, 4, "rd_nolast");
      r_last_cfg = 1;
      b_resp_cfg = RESP_DECERR;
      do_req(1, 10'h040, 32'h0BADF00D, 4'hF, 1, 4, "wr_decerr");
      b_resp_cfg = RESP_OKAY;
      do_req(1, 10'h3FF, 32'h12345678, 4'hF, 0, 4, "wr_top");

      // Park a write in WR_RESP, then reset underneath it.
      b_hold = 1;
      exp_aw_q.push_back(32'h0000_0140);
      exp_w_q.push_back({4'hF, 32'h55AA55AA});
      @(negedge clk);
      sram_req = 1; sram_write_en = 1; sram_addr = 10'h050; sram_write_data = 32'h55AA55AA;
      sram_byte_en = 4'hF;
      n = 0;
      while (!BREADY && n < 20) begin @(posedge clk); #1; n++; end
      check_eq("rst_reached_wr_resp", BREADY, 1);
      a0 = ack_cnt;
      @(negedge clk);
      rst_n = 0;
      sram_req = 0;
      @(posedge clk); #1;
      check_eq("midrst_valids", {AWVALID, WVALID, ARVALID, BREADY, RREADY}, 5'b00000);
      check_eq("midrst_ack_err", {sram_ack, sram_err}, 2'b00);
      @(negedge clk);
      b_hold = 0;
      rst_n = 1;
      repeat (3) @(posedge clk);
      #1 check_eq("midrst_no_ack", 32'(ack_cnt - a0), 32'd0);
      do_req(0, 10'h010, 32'h0, 4'h0, 0, 4, "rd_after_rst");

      @(negedge clk);
      x_req = 1; x_we = 1; x_addr = 10'h3FF; x_wdata = 32'hA5A5A5A5; x_be = 4'hF;
      n = 0;
      while (!x_AWVALID && n < 10) begin @(posedge clk); #1; n++; end
      check_eq("base_awvalid", x_AWVALID, 1);
      check_eq("base_awaddr", x_AWADDR, 32'h1000_0FFC);
      x_req = 0;

      check_eq("queues_drained", 32'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
